// File: rtl/rbs_ring_master.sv
// Ring bus master: turns one host transaction at a time into a single ring request word
// and waits for the matching word to come back around the ring, or for a timeout.
module rbs_ring_master #(
  parameter int unsigned C_RBS_ADDR_WIDTH = 32,
  parameter int unsigned C_RBS_DATA_WIDTH = 32,
  parameter int unsigned C_RBS_SRC_WIDTH  = 2,
  parameter int unsigned C_MASTER_SRC     = 0,
  parameter int unsigned C_TIMEOUT        = 255
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          HOST_REQ_VALID,
  output logic                          HOST_REQ_RDY,
  input  logic                          HOST_RD_WR_L,
  input  logic [C_RBS_ADDR_WIDTH-3:0]   HOST_ADDR,
  input  logic [C_RBS_DATA_WIDTH-1:0]   HOST_WR_DATA,
  output logic                          HOST_RESP_VALID,
  output logic [C_RBS_DATA_WIDTH-1:0]   HOST_RESP_DATA,
  output logic [1:0]                    HOST_RESP_STATUS,
  output logic                          M_RBS_REQ,
  output logic                          M_RBS_ACK,
  output logic                          M_RBS_RD_WR_L,
  output logic [C_RBS_ADDR_WIDTH-3:0]   M_RBS_ADDR,
  output logic [C_RBS_DATA_WIDTH-1:0]   M_RBS_DATA,
  output logic [C_RBS_SRC_WIDTH-1:0]    M_RBS_SRC,
  input  logic                          S_RBS_REQ,
  input  logic                          S_RBS_ACK,
  input  logic                          S_RBS_RD_WR_L,
  input  logic [C_RBS_ADDR_WIDTH-3:0]   S_RBS_ADDR,
  input  logic [C_RBS_DATA_WIDTH-1:0]   S_RBS_DATA,
  input  logic [C_RBS_SRC_WIDTH-1:0]    S_RBS_SRC
);

  localparam int unsigned AW = C_RBS_ADDR_WIDTH - 2;
  localparam int unsigned DW = C_RBS_DATA_WIDTH;
  localparam int unsigned SW = C_RBS_SRC_WIDTH;
  localparam int unsigned CW = 16;

  localparam logic [SW-1:0] MASTER_SRC = SW'(C_MASTER_SRC);
  localparam logic [CW-1:0] TO_LAST    = CW'(C_TIMEOUT - 1);
  localparam logic [DW-1:0] UNCLAIMED  = DW'(32'hDEADBEEF);

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_UNCLAIMED = 2'b01;
  localparam logic [1:0] ST_TIMEOUT   = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cap_rd_q, cap_rd_d;
  logic [AW-1:0]   cap_addr_q, cap_addr_d;
  logic [DW-1:0]   cap_data_q, cap_data_d;

  logic            rdy_q, rdy_d;
  logic            resp_valid_q, resp_valid_d;
  logic [DW-1:0]   resp_data_q, resp_data_d;
  logic [1:0]      resp_status_q, resp_status_d;

  logic            m_req_q, m_req_d;
  logic            m_rd_q, m_rd_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic [SW-1:0]   m_src_q, m_src_d;

  logic            match;

  // Next-state logic; every output register is derived from the next state so it
  // lines up with the state it belongs to.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cap_rd_d      = cap_rd_q;
    cap_addr_d    = cap_addr_q;
    cap_data_d    = cap_data_q;
    resp_data_d   = resp_data_q;
    resp_status_d = resp_status_q;

    match = S_RBS_REQ && (S_RBS_SRC == MASTER_SRC) &&
            (S_RBS_ADDR == cap_addr_q) && (S_RBS_RD_WR_L == cap_rd_q);

    case (state_q)
      IDLE: begin
        if (HOST_REQ_VALID && rdy_q) begin
          cap_rd_d   = HOST_RD_WR_L;
          cap_addr_d = HOST_ADDR;
          cap_data_d = HOST_WR_DATA;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A match on the last wait cycle takes priority over the timeout.
        if (match) begin
          state_d = RESP;
          if (S_RBS_ACK) begin
            resp_status_d = ST_OK;
            resp_data_d   = cap_rd_q ? S_RBS_DATA : '0;
          end else begin
            resp_status_d = ST_UNCLAIMED;
            resp_data_d   = UNCLAIMED;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d       = RESP;
          resp_status_d = ST_TIMEOUT;
          resp_data_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rdy_d        = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    m_req_d      = (state_d == ISSUE);
    m_rd_d       = m_req_d && cap_rd_d;
    m_addr_d     = m_req_d ? cap_addr_d : '0;
    m_data_d     = (m_req_d && !cap_rd_d) ? cap_data_d : '0;
    m_src_d      = m_req_d ? MASTER_SRC : '0;
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cap_rd_q      <= 1'b0;
      cap_addr_q    <= '0;
      cap_data_q    <= '0;
      rdy_q         <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_status_q <= ST_OK;
      m_req_q       <= 1'b0;
      m_rd_q        <= 1'b0;
      m_addr_q      <= '0;
      m_data_q      <= '0;
      m_src_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cap_rd_q      <= cap_rd_d;
      cap_addr_q    <= cap_addr_d;
      cap_data_q    <= cap_data_d;
      rdy_q         <= rdy_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_status_q <= resp_status_d;
      m_req_q       <= m_req_d;
      m_rd_q        <= m_rd_d;
      m_addr_q      <= m_addr_d;
      m_data_q      <= m_data_d;
      m_src_q       <= m_src_d;
    end
  end

  assign HOST_REQ_RDY     = rdy_q;
  assign HOST_RESP_VALID  = resp_valid_q;
  assign HOST_RESP_DATA   = resp_data_q;
  assign HOST_RESP_STATUS = resp_status_q;

  // The master never acknowledges its own requests.
  assign M_RBS_ACK     = 1'b0;
  assign M_RBS_REQ     = m_req_q;
  assign M_RBS_RD_WR_L = m_rd_q;
  assign M_RBS_ADDR    = m_addr_q;
  assign M_RBS_DATA    = m_data_q;
  assign M_RBS_SRC     = m_src_q;

endmodule

// File: tb/tb_rbs_ring_master.sv
// Bench for rbs_ring_master: emulates the ring around the master and predicts every
// response (data, status, arrival cycle) from the transaction outcome alone.
module tb_rbs_ring_master;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int MS = 1;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          HOST_REQ_VALID;
  logic          HOST_REQ_RDY;
  logic          HOST_RD_WR_L;
  logic [AW-1:0] HOST_ADDR;
  logic [DW-1:0] HOST_WR_DATA;
  logic          HOST_RESP_VALID;
  logic [DW-1:0] HOST_RESP_DATA;
  logic [1:0]    HOST_RESP_STATUS;
  logic          M_RBS_REQ, M_RBS_ACK, M_RBS_RD_WR_L;
  logic [AW-1:0] M_RBS_ADDR;
  logic [DW-1:0] M_RBS_DATA;
  logic [SW-1:0] M_RBS_SRC;
  logic          S_RBS_REQ, S_RBS_ACK, S_RBS_RD_WR_L;
  logic [AW-1:0] S_RBS_ADDR;
  logic [DW-1:0] S_RBS_DATA;
  logic [SW-1:0] S_RBS_SRC;

  always #5 CLK = ~CLK;

  rbs_ring_master #(
    .C_RBS_ADDR_WIDTH (AW + 2),
    .C_RBS_DATA_WIDTH (DW),
    .C_RBS_SRC_WIDTH  (SW),
    .C_MASTER_SRC     (MS),
    .C_TIMEOUT        (TO)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .HOST_REQ_VALID   (HOST_REQ_VALID),
    .HOST_REQ_RDY     (HOST_REQ_RDY),
    .HOST_RD_WR_L     (HOST_RD_WR_L),
    .HOST_ADDR        (HOST_ADDR),
    .HOST_WR_DATA     (HOST_WR_DATA),
    .HOST_RESP_VALID  (HOST_RESP_VALID),
    .HOST_RESP_DATA   (HOST_RESP_DATA),
    .HOST_RESP_STATUS (HOST_RESP_STATUS),
    .M_RBS_REQ        (M_RBS_REQ),
    .M_RBS_ACK        (M_RBS_ACK),
    .M_RBS_RD_WR_L    (M_RBS_RD_WR_L),
    .M_RBS_ADDR       (M_RBS_ADDR),
    .M_RBS_DATA       (M_RBS_DATA),
    .M_RBS_SRC        (M_RBS_SRC),
    .S_RBS_REQ        (S_RBS_REQ),
    .S_RBS_ACK        (S_RBS_ACK),
    .S_RBS_RD_WR_L    (S_RBS_RD_WR_L),
    .S_RBS_ADDR       (S_RBS_ADDR),
    .S_RBS_DATA       (S_RBS_DATA),
    .S_RBS_SRC        (S_RBS_SRC)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_m    = 0;
  int exp_r    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Counts ring request pulses, response pulses and any non-zero ring head outside a request.
  bit mon_en   = 1'b0;
  int m_pulses = 0;
  int r_pulses = 0;
  int m_leak   = 0;
  always @(negedge CLK) begin
    if (mon_en) begin
      if (M_RBS_REQ === 1'b1) m_pulses++;
      if (HOST_RESP_VALID === 1'b1) r_pulses++;
      if (M_RBS_ACK !== 1'b0 ||
          (M_RBS_REQ !== 1'b1 && {M_RBS_RD_WR_L, M_RBS_ADDR, M_RBS_DATA, M_RBS_SRC} !== '0))
        m_leak++;
    end
  end

  logic          nx_rd;
  logic [AW-1:0] nx_addr;
  logic [DW-1:0] nx_data;

  task automatic s_clear();
    S_RBS_REQ = 1'b0; S_RBS_ACK = 1'b0; S_RBS_RD_WR_L = 1'b0;
    S_RBS_ADDR = '0; S_RBS_DATA = '0; S_RBS_SRC = '0;
  endtask

  task automatic s_drive(input logic ack, input logic rd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [SW-1:0] src);
    S_RBS_REQ = 1'b1; S_RBS_ACK = ack; S_RBS_RD_WR_L = rd;
    S_RBS_ADDR = addr; S_RBS_DATA = data; S_RBS_SRC = src;
  endtask

  // While busy, the host either holds the next transaction or toggles random junk.
  task automatic drive_host(input bit hold);
    if (hold) begin
      HOST_REQ_VALID = 1'b1; HOST_RD_WR_L = nx_rd; HOST_ADDR = nx_addr; HOST_WR_DATA = nx_data;
    end else begin
      HOST_REQ_VALID = 1'($urandom_range(0, 1));
      HOST_RD_WR_L   = 1'($urandom);
      HOST_ADDR      = AW'($urandom);
      HOST_WR_DATA   = $urandom;
    end
  endtask

  // kind: 0 acked, 1 unclaimed, 2 no return. d: cycle after ISSUE at which the ring returns.
  // fmode: -1 none, 0 foreign src, 1 wrong addr, 2 wrong direction; injected at cycle fc.
  task automatic run_txn(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] rdata, input int kind, input int d,
                         input int fmode, input int fc, input bit hold, input bit late);
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_status;
    int            exp_c;
    bit            got;
    int            rc;
    logic [AW-1:0] fa;
    logic          fr;
    logic [SW-1:0] fs;
    exp_status = (kind == 0) ? 2'b00 : (kind == 1) ? 2'b01 : 2'b10;
    exp_data   = (kind == 0) ? (rd ? rdata : '0) : (kind == 1) ? 32'hDEADBEEF : '0;
    exp_c      = (kind == 2) ? TO + 1 : d + 1;
    exp_m++;
    exp_r++;

    check_eq("rdy_idle", 64'(HOST_REQ_RDY), 64'(1));
    HOST_REQ_VALID = 1'b1; HOST_RD_WR_L = rd; HOST_ADDR = addr; HOST_WR_DATA = wdata;
    @(negedge CLK);
    check_eq("issue_req",  64'(M_RBS_REQ), 64'(1));
    check_eq("issue_rd",   64'(M_RBS_RD_WR_L), 64'(rd));
    check_eq("issue_addr", 64'(M_RBS_ADDR), 64'(addr));
    check_eq("issue_src",  64'(M_RBS_SRC), 64'(MS));
    check_eq("issue_data", 64'(M_RBS_DATA), rd ? 64'(0) : 64'(wdata));
    check_eq("issue_rdy",  64'(HOST_REQ_RDY), 64'(0));
    drive_host(hold);

    got = 1'b0;
    rc  = 0;
    for (int c = 1; c <= TO + 4 && !got; c++) begin
      @(negedge CLK);
      s_clear();
      if (HOST_RESP_VALID === 1'b1) begin
        got = 1'b1;
        rc  = c;
        check_eq("resp_data",   64'(HOST_RESP_DATA), 64'(exp_data));
        check_eq("resp_status", 64'(HOST_RESP_STATUS), 64'(exp_status));
        if (hold) drive_host(1'b1);
        else HOST_REQ_VALID = 1'b0;
        if (late) s_drive(1'b1, rd, addr, rdata, SW'(MS));
      end else begin
        drive_host(hold);
        if (kind != 2 && c == d) begin
          s_drive(kind == 0, rd, addr, rd ? rdata : wdata, SW'(MS));
        end else if (fmode >= 0 && c == fc) begin
          fa = addr; fr = rd; fs = SW'(MS);
          if (fmode == 0) fs = SW'(MS + 1);
          else if (fmode == 1) fa = addr ^ AW'(1);
          else fr = ~rd;
          s_drive(1'($urandom), fr, fa, $urandom, fs);
        end
      end
    end
    check_eq("resp_seen",  64'(got), 64'(1));
    check_eq("resp_cycle", 64'(rc), 64'(exp_c));

    @(negedge CLK);
    s_clear();
    check_eq("resp_pulse", 64'(HOST_RESP_VALID), 64'(0));
    check_eq("rdy_after",  64'(HOST_REQ_RDY), 64'(1));
    check_eq("hold_data",  64'(HOST_RESP_DATA), 64'(exp_data));
    check_eq("hold_stat",  64'(HOST_RESP_STATUS), 64'(exp_status));
  endtask

  // Reset pulse while waiting aborts the transaction; a later matching word must be dropped.
  task automatic reset_mid_wait();
    logic [AW-1:0] a;
    int            noisy;
    a = AW'(32'h155);
    exp_m++;
    check_eq("rst_rdy_pre", 64'(HOST_REQ_RDY), 64'(1));
    HOST_REQ_VALID = 1'b1; HOST_RD_WR_L = 1'b1; HOST_ADDR = a; HOST_WR_DATA = '0;
    @(negedge CLK);
    HOST_REQ_VALID = 1'b0;
    check_eq("rst_issue", 64'(M_RBS_REQ), 64'(1));
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check_eq("rst_rdy",    64'(HOST_REQ_RDY), 64'(0));
    check_eq("rst_rvalid", 64'(HOST_RESP_VALID), 64'(0));
    check_eq("rst_rdata",  64'(HOST_RESP_DATA), 64'(0));
    check_eq("rst_rstat",  64'(HOST_RESP_STATUS), 64'(0));
    check_eq("rst_mreq",   64'(M_RBS_REQ), 64'(0));
    RESET = 1'b0;
    s_drive(1'b1, 1'b1, a, 32'h99999999, SW'(MS));
    @(negedge CLK);
    s_clear();
    check_eq("rst_rdy_post", 64'(HOST_REQ_RDY), 64'(1));
    check_eq("rst_m_zero",   64'({M_RBS_REQ, M_RBS_ACK, M_RBS_RD_WR_L, M_RBS_ADDR, M_RBS_SRC}), 64'(0));
    noisy = 0;
    if (HOST_RESP_VALID !== 1'b0) noisy++;
    repeat (3) begin
      @(negedge CLK);
      if (HOST_RESP_VALID !== 1'b0) noisy++;
    end
    check_eq("rst_no_resp", 64'(noisy), 64'(0));
  endtask

  logic          cur_rd;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  int            kind, d, fm, fc;
  bit            hold;

  initial begin
    RESET = 1'b1;
    HOST_REQ_VALID = 1'b0; HOST_RD_WR_L = 1'b0; HOST_ADDR = '0; HOST_WR_DATA = '0;
    s_clear();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("reset_rdy",    64'(HOST_REQ_RDY), 64'(0));
    check_eq("reset_rvalid", 64'(HOST_RESP_VALID), 64'(0));
    check_eq("reset_rdata",  64'(HOST_RESP_DATA), 64'(0));
    check_eq("reset_rstat",  64'(HOST_RESP_STATUS), 64'(0));
    check_eq("reset_mreq",   64'(M_RBS_REQ), 64'(0));
    RESET  = 1'b0;
    mon_en = 1'b1;
    @(negedge CLK);
    check_eq("rdy_first", 64'(HOST_REQ_RDY), 64'(1));

    run_txn(1'b1, AW'(32'h0040010), '0, 32'h12345678, 0, 3, -1, 0, 1'b0, 1'b0);
    reset_mid_wait();
    run_txn(1'b0, AW'(32'h10), 32'hA5A5A5A5, '0, 1, 2, -1, 0, 1'b0, 1'b0);
    run_txn(1'b1, AW'(32'h123), '0, 32'h13572468, 2, 0, -1, 0, 1'b0, 1'b1);
    run_txn(1'b1, AW'(32'h2000), '0, 32'hCAFEF00D, 0, 4, 0, 1, 1'b0, 1'b0);
    run_txn(1'b1, AW'(32'h77), '0, 32'h0BADF00D, 0, TO, 1, 2, 1'b0, 1'b0);

    nx_rd = 1'b0; nx_addr = AW'(32'h3FF); nx_data = 32'h55AA55AA;
    run_txn(1'b1, AW'(32'h3FE), '0, 32'h11112222, 0, 2, 2, 1, 1'b1, 1'b0);
    run_txn(nx_rd, nx_addr, nx_data, '0, 0, 5, -1, 0, 1'b0, 1'b0);

    cur_rd = 1'($urandom); cur_addr = AW'($urandom); cur_data = $urandom;
    for (int i = 0; i < 40; i++) begin
      nx_rd = 1'($urandom); nx_addr = AW'($urandom); nx_data = $urandom;
      kind = int'($urandom_range(0, 2));
      d    = int'($urandom_range(1, TO));
      fm   = int'($urandom_range(0, 3)) - 1;
      if (kind == 2) fc = int'($urandom_range(1, TO));
      else if (d > 1) fc = int'($urandom_range(1, d - 1));
      else begin fc = 0; fm = -1; end
      hold = ($urandom_range(0, 3) == 0);
      run_txn(cur_rd, cur_addr, cur_data, $urandom, kind, d, fm, fc, hold, kind == 2);
      cur_rd = nx_rd; cur_addr = nx_addr; cur_data = nx_data;
    end

    HOST_REQ_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    check_eq("m_pulse_count", 64'(m_pulses), 64'(exp_m));
    check_eq("r_pulse_count", 64'(r_pulses), 64'(exp_r));
    check_eq("m_idle_zero",   64'(m_leak), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rbs_ring_master.md
RBS_RING_MASTER -- requirements
Module: rbs_ring_master

Interface
REQ-001 Parameters SHALL be: C_RBS_ADDR_WIDTH, 32, ring address width (ring carries C_RBS_ADDR_WIDTH-2 word-address bits); C_RBS_DATA_WIDTH, 32, ring data width; C_RBS_SRC_WIDTH, 2, ring source-tag width; C_MASTER_SRC, 0, source tag this master stamps on its requests; C_TIMEOUT, 255, wait cycles before timeout (1..65535).
REQ-002 Ports: CLK, in, 1, sole clock; all logic on rising edge.
REQ-003 Ports: RESET, in, 1, synchronous, active-high reset.
REQ-004 Ports: HOST_REQ_VALID, in, 1, host transaction present.
REQ-005 Ports: HOST_REQ_RDY, out, 1, block accepts transaction.
REQ-006 Ports: HOST_RD_WR_L, in, 1, 1=read, 0=write.
REQ-007 Ports: HOST_ADDR, in, C_RBS_ADDR_WIDTH-2, word address.
REQ-008 Ports: HOST_WR_DATA, in, C_RBS_DATA_WIDTH, write data.
REQ-009 Ports: HOST_RESP_VALID, out, 1, one-cycle completion pulse.
REQ-010 Ports: HOST_RESP_DATA, out, C_RBS_DATA_WIDTH, read data.
REQ-011 Ports: HOST_RESP_STATUS, out, 2, 00 ok, 01 unclaimed, 10 timeout.
REQ-012 Ports: M_RBS_REQ/M_RBS_ACK/M_RBS_RD_WR_L (1 each), M_RBS_ADDR (C_RBS_ADDR_WIDTH-2), M_RBS_DATA (C_RBS_DATA_WIDTH), M_RBS_SRC (C_RBS_SRC_WIDTH), out, ring head driven into first ring node.
REQ-013 Ports: S_RBS_REQ/S_RBS_ACK/S_RBS_RD_WR_L/S_RBS_ADDR/S_RBS_DATA/S_RBS_SRC, in, same widths, ring tail returned from last ring node.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; HOST_REQ_RDY=1 only in IDLE.
REQ-015 IDLE: on HOST_REQ_VALID&HOST_REQ_RDY, capture rd_wr_L, addr, wr_data; go ISSUE.
REQ-016 ISSUE: exactly one cycle of M_RBS_REQ=1, M_RBS_ACK=0, M_RBS_SRC=C_MASTER_SRC, captured rd_wr_L/addr; M_RBS_DATA=captured data for writes, 0 for reads; timeout counter cleared; go WAIT.
REQ-017 All M_RBS_* outputs SHALL be registered and 0 in every cycle other than ISSUE.
REQ-018 WAIT: a return matches when S_RBS_REQ=1, S_RBS_SRC=C_MASTER_SRC, S_RBS_ADDR=captured addr, S_RBS_RD_WR_L=captured rd_wr_L.
REQ-019 On match with S_RBS_ACK=1: status 00, response data = S_RBS_DATA for read, 0 for write; go RESP.
REQ-020 On match with S_RBS_ACK=0: status 01, response data 0xDEADBEEF truncated to C_RBS_DATA_WIDTH; go RESP.
REQ-021 Timeout counter (16 bits) increments each WAIT cycle without match; when it equals C_TIMEOUT-1 without match: status 10, data 0; go RESP. Match in same cycle as timeout wins.
REQ-022 RESP: HOST_RESP_VALID=1 for exactly one cycle with registered data/status; go IDLE; HOST_RESP_DATA/STATUS hold until next RESP.
REQ-023 Latency: accept at cycle N -> M_RBS_REQ at N+1; matching return at cycle K -> HOST_RESP_VALID at K+1.
REQ-024 Non-matching S_RBS_REQ=1 words (foreign src, wrong addr, or arriving outside WAIT, e.g., late return after timeout) SHALL be discarded with no output effect.
REQ-025 HOST_REQ_VALID asserted outside IDLE SHALL be ignored (not captured) until IDLE.

Reset
REQ-026 RESET=1 at any clock edge, including mid-WAIT, SHALL force IDLE, clear counter and captured fields, drive all M_RBS_* 0, HOST_RESP_VALID 0, HOST_RESP_DATA 0, HOST_RESP_STATUS 00, HOST_REQ_RDY 0; no response SHALL be emitted for an aborted transaction.
REQ-027 HOST_REQ_RDY SHALL be 1 in the first cycle after RESET deasserts.

Verification
REQ-028 Read ok: host read addr 0x0040010; ring loopback with 3-cycle node claiming, ACK=1, data 0x12345678 -> M_RBS_REQ pulse at N+1, HOST_RESP_VALID one cycle, data 0x12345678, status 00.
REQ-029 Write unclaimed: write addr 0x10, data 0xA5A5A5A5; ring returns word unchanged (ACK=0) -> M_RBS_DATA 0xA5A5A5A5 in ISSUE, status 01, data 0xDEADBEEF.
REQ-030 Timeout: C_TIMEOUT=8, ring returns nothing -> HOST_RESP_VALID exactly 9 cycles after M_RBS_REQ cycle, status 10; late return afterwards -> no HOST_RESP_VALID.
REQ-031 Foreign traffic: during WAIT inject S_RBS_REQ with SRC=C_MASTER_SRC+1, then matching ACK=1 return -> only one response, from matching word.
REQ-032 Reset mid-WAIT: RESET one cycle while in WAIT, then matching return -> no HOST_RESP_VALID, HOST_REQ_RDY=1 next cycle, all M_RBS_* 0.
REQ-033 Back-to-back: HOST_REQ_VALID held high across two transactions -> second accepted only in IDLE after first RESP; exactly two M_RBS_REQ pulses.
